// File: rtl/control_link_slave.sv
// ----------------------------------------------------------------------------
// control_link_slave
//
// Far-end responder for the 8b10b control link. It parses 8-byte request
// frames (K28.5 comma + 7 bytes) from the decoder, runs one register-bus read
// or write for each new request, and streams 8-byte response frames back to
// the encoder.
//
// The link uses a 4-phase handshake. The response ack bit rises once the bus
// cycle is done. It falls again when a frame with req=0 arrives.
//
// Parameters
//   BUS_TIMEOUT   bus_ack wait limit in clk cycles (1..255)
//   TIMEOUT_DATA  response data returned when the bus times out
//
// Ports
//   clk, reset_n            byte clock, synchronous active-low reset
//   rx_byte/rx_isk          decoded byte and its K flag
//   rx_link_ok              decoder lock
//   tx_byte/tx_isk          byte and K flag to the encoder (registered)
//   bus_addr/bus_wdata      register address / write data (held per request)
//   bus_we/bus_re           one-cycle write / read strobes
//   bus_rdata/bus_ack       read data and bus-cycle completion
//   busy                    request in progress (FSM not idle)
//   frame_errs              saturating framing-error count
//
// Handshake note: the bus side has no backpressure. A strobe starts a cycle,
// and the cycle ends on the first bus_ack seen after the strobe cycle, or on
// timeout. No new strobe is issued until the link handshake returns to idle.
// ----------------------------------------------------------------------------
module control_link_slave #(
    parameter logic [7:0]  BUS_TIMEOUT  = 8'd255,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_isk,
    input  logic        rx_link_ok,
    output logic [7:0]  tx_byte,
    output logic        tx_isk,
    output logic [15:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    output logic        bus_re,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        busy,
    output logic [7:0]  frame_errs
);

    localparam logic [7:0] K28_5 = 8'hBC;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUS_REQ  = 2'd1,
        ST_BUS_WAIT = 2'd2,
        ST_ACK_HI   = 2'd3
    } state_e;

    // ------------------------------------------------------------------------
    // RX parser state
    // ------------------------------------------------------------------------
    logic        in_sync_q, in_sync_d;
    logic [3:0]  rx_cnt_q, rx_cnt_d;       // next byte index 1..7; 8 = frame complete
    logic        frame_valid_q, frame_valid_d;
    logic        f_req_q, f_req_d;
    logic        f_wr_q, f_wr_d;
    logic [15:0] f_addr_q, f_addr_d;
    logic [31:0] f_wdata_q, f_wdata_d;
    logic [7:0]  frame_errs_q, frame_errs_d;

    // ------------------------------------------------------------------------
    // Bus FSM state
    // ------------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [15:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        wr_q, wr_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic        resp_ack_q, resp_ack_d;
    logic        resp_to_q, resp_to_d;
    logic [31:0] resp_data_q, resp_data_d;

    // ------------------------------------------------------------------------
    // TX state
    // ------------------------------------------------------------------------
    logic [2:0]  tx_ptr_q, tx_ptr_d;
    logic        sh_ack_q, sh_ack_d;
    logic        sh_to_q, sh_to_d;
    logic [31:0] sh_data_q, sh_data_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        tx_isk_q, tx_isk_d;

    // ------------------------------------------------------------------------
    // RX parser
    // ------------------------------------------------------------------------
    always_comb begin
        logic frame_err;
        in_sync_d     = in_sync_q;
        rx_cnt_d      = rx_cnt_q;
        frame_valid_d = 1'b0;
        f_req_d       = f_req_q;
        f_wr_d        = f_wr_q;
        f_addr_d      = f_addr_q;
        f_wdata_d     = f_wdata_q;
        frame_err     = 1'b0;

        if (!rx_link_ok) begin
            // Loss of lock only drops sync. It is not a framing error.
            in_sync_d = 1'b0;
        end else if (rx_isk && rx_byte == K28_5) begin
            // A comma that cuts a partial frame counts as an error.
            // Back-to-back commas (rx_cnt==1) and a comma after a complete
            // frame (rx_cnt==8) are normal idle/framing traffic.
            if (in_sync_q && rx_cnt_q >= 4'd2 && rx_cnt_q <= 4'd7) begin
                frame_err = 1'b1;
            end
            in_sync_d = 1'b1;
            rx_cnt_d  = 4'd1;
        end else if (rx_isk) begin
            if (in_sync_q) begin
                frame_err = 1'b1;
                in_sync_d = 1'b0;
            end
        end else if (in_sync_q) begin
            if (rx_cnt_q == 4'd8) begin
                // Data after byte 7 without a comma means the frame is too long.
                frame_err = 1'b1;
                in_sync_d = 1'b0;
            end else begin
                case (rx_cnt_q)
                    4'd1: begin
                        f_req_d = rx_byte[0];
                        f_wr_d  = rx_byte[1];
                    end
                    4'd2:    f_addr_d[7:0]    = rx_byte;
                    4'd3:    f_addr_d[15:8]   = rx_byte;
                    4'd4:    f_wdata_d[7:0]   = rx_byte;
                    4'd5:    f_wdata_d[15:8]  = rx_byte;
                    4'd6:    f_wdata_d[23:16] = rx_byte;
                    4'd7:    f_wdata_d[31:24] = rx_byte;
                    default: ;
                endcase
                rx_cnt_d      = rx_cnt_q + 4'd1;
                frame_valid_d = (rx_cnt_q == 4'd7);
            end
        end

        frame_errs_d = frame_errs_q;
        if (frame_err && frame_errs_q != 8'hFF) begin
            frame_errs_d = frame_errs_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Bus / handshake FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        wr_d        = wr_q;
        tmo_cnt_d   = tmo_cnt_q;
        resp_ack_d  = resp_ack_q;
        resp_to_d   = resp_to_q;
        resp_data_d = resp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (frame_valid_q && f_req_q) begin
                    bus_addr_d  = f_addr_q;
                    bus_wdata_d = f_wdata_q;
                    wr_d        = f_wr_q;
                    state_d     = ST_BUS_REQ;
                end
            end
            ST_BUS_REQ: begin
                // The strobe is asserted combinationally in this state.
                // Any bus_ack seen now belongs to nothing and is ignored.
                tmo_cnt_d = 8'd0;
                state_d   = ST_BUS_WAIT;
            end
            ST_BUS_WAIT: begin
                // Link loss does not abort a bus cycle that has started.
                if (bus_ack) begin
                    resp_data_d = wr_q ? 32'h0 : bus_rdata;
                    resp_to_d   = 1'b0;
                    resp_ack_d  = 1'b1;
                    state_d     = ST_ACK_HI;
                end else if (tmo_cnt_q == BUS_TIMEOUT - 8'd1) begin
                    // BUS_TIMEOUT cycles have been spent here without an ack.
                    resp_data_d = TIMEOUT_DATA;
                    resp_to_d   = 1'b1;
                    resp_ack_d  = 1'b1;
                    state_d     = ST_ACK_HI;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            ST_ACK_HI: begin
                // Repeated req=1 frames keep the ack high and start no new cycle.
                if (!rx_link_ok || (frame_valid_q && !f_req_q)) begin
                    resp_ack_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus_we     = (state_q == ST_BUS_REQ) &&  wr_q;
    assign bus_re     = (state_q == ST_BUS_REQ) && !wr_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_errs = frame_errs_q;

    // ------------------------------------------------------------------------
    // TX framer. The shadow registers are loaded while byte 7 is emitted.
    // This keeps every transmitted frame internally consistent.
    // ------------------------------------------------------------------------
    always_comb begin
        tx_ptr_d  = tx_ptr_q + 3'd1;
        sh_ack_d  = sh_ack_q;
        sh_to_d   = sh_to_q;
        sh_data_d = sh_data_q;
        tx_isk_d  = 1'b0;
        tx_byte_d = 8'h00;

        if (tx_ptr_q == 3'd7) begin
            sh_ack_d  = resp_ack_q;
            sh_to_d   = resp_to_q;
            sh_data_d = resp_data_q;
        end

        case (tx_ptr_q)
            3'd0: begin
                tx_byte_d = K28_5;
                tx_isk_d  = 1'b1;
            end
            3'd1:    tx_byte_d = {6'h0, sh_to_q, sh_ack_q};
            3'd2:    tx_byte_d = sh_data_q[7:0];
            3'd3:    tx_byte_d = sh_data_q[15:8];
            3'd4:    tx_byte_d = sh_data_q[23:16];
            3'd5:    tx_byte_d = sh_data_q[31:24];
            default: tx_byte_d = 8'h00;
        endcase
    end

    assign tx_byte = tx_byte_q;
    assign tx_isk  = tx_isk_q;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_sync_q     <= 1'b0;
            rx_cnt_q      <= 4'd0;
            frame_valid_q <= 1'b0;
            f_req_q       <= 1'b0;
            f_wr_q        <= 1'b0;
            f_addr_q      <= 16'h0;
            f_wdata_q     <= 32'h0;
            frame_errs_q  <= 8'h00;
            state_q       <= ST_IDLE;
            bus_addr_q    <= 16'h0;
            bus_wdata_q   <= 32'h0;
            wr_q          <= 1'b0;
            tmo_cnt_q     <= 8'd0;
            resp_ack_q    <= 1'b0;
            resp_to_q     <= 1'b0;
            resp_data_q   <= 32'h0;
            tx_ptr_q      <= 3'd0;
            sh_ack_q      <= 1'b0;
            sh_to_q       <= 1'b0;
            sh_data_q     <= 32'h0;
            tx_byte_q     <= 8'h00;
            tx_isk_q      <= 1'b0;
        end else begin
            in_sync_q     <= in_sync_d;
            rx_cnt_q      <= rx_cnt_d;
            frame_valid_q <= frame_valid_d;
            f_req_q       <= f_req_d;
            f_wr_q        <= f_wr_d;
            f_addr_q      <= f_addr_d;
            f_wdata_q     <= f_wdata_d;
            frame_errs_q  <= frame_errs_d;
            state_q       <= state_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            wr_q          <= wr_d;
            tmo_cnt_q     <= tmo_cnt_d;
            resp_ack_q    <= resp_ack_d;
            resp_to_q     <= resp_to_d;
            resp_data_q   <= resp_data_d;
            tx_ptr_q      <= tx_ptr_d;
            sh_ack_q      <= sh_ack_d;
            sh_to_q       <= sh_to_d;
            sh_data_q     <= sh_data_d;
            tx_byte_q     <= tx_byte_d;
            tx_isk_q      <= tx_isk_d;
        end
    end

endmodule
